// File: rtl/dmem_pkg.sv
// Shared phase encodings and default widths for the streamed data memory.
package dmem_pkg;
  localparam int unsigned DMEM_DATA_W = 8;
  localparam int unsigned DMEM_ADDR_W = 16;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    LOAD = 2'b01,
    RUN  = 2'b10,
    DUMP = 2'b11
  } state_e;
endpackage

// File: rtl/dmem_stream_if.sv
// Load and dump valid/ready streams between the host I/O path and dmem_stream.
interface dmem_stream_if
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W
);
  logic              ld_valid;
  logic [DATA_W-1:0] ld_data;
  logic              ld_ready;
  logic              dump_valid;
  logic [DATA_W-1:0] dump_data;
  logic              dump_ready;

  modport master (
    output ld_valid, ld_data, dump_ready,
    input  ld_ready, dump_valid, dump_data
  );

  modport slave (
    input  ld_valid, ld_data, dump_ready,
    output ld_ready, dump_valid, dump_data
  );
endinterface

// File: rtl/dmem_sram.sv
// Single-port synchronous RAM with a registered, read-first read port.
module dmem_sram
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);
  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[addr_i] <= wdata_i;
    if (re_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/dmem_stream.sv
// Streamed load/run/dump data memory: host loads an image, the core accesses it, the result is dumped.
module dmem_stream
  import dmem_pkg::*;
#(
  parameter int unsigned DATA_W = DMEM_DATA_W,
  parameter int unsigned ADDR_W = DMEM_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rd_en,
  input  logic [ADDR_W:0]   len,
  output logic              rd_done,
  input  logic [ADDR_W-1:0] addr,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              wr_en,
  output logic              wr_done,
  output logic [1:0]        state,
  dmem_stream_if.slave      strm
);
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  state_e            state_q;
  logic [ADDR_W:0]   len_q, ld_cnt_q, rd_cnt_q, out_cnt_q;
  logic              ld_ready_q, rd_done_q, wr_done_q;
  logic              dout_valid_q;
  logic [DATA_W-1:0] dout_hold_q;
  logic              pend_q, dv_q, sv_q;
  logic [DATA_W-1:0] dd_q, sd_q;

  logic              ld_fire, pop, issue;
  logic [1:0]        occ;
  logic              o_v_d, s_v_d;
  logic [DATA_W-1:0] o_d_d, s_d_d;
  logic              ram_we, ram_re;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata, ram_rdata;

  dmem_sram #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) u_sram (
    .clk     (clk),
    .we_i    (ram_we),
    .re_i    (ram_re),
    .addr_i  (ram_addr),
    .wdata_i (ram_wdata),
    .rdata_o (ram_rdata)
  );

  assign ld_fire = (state_q == LOAD) && ld_ready_q && strm.ld_valid;
  assign pop     = dv_q && strm.dump_ready;
  assign occ     = {1'b0, dv_q} + {1'b0, sv_q} + {1'b0, pend_q};
  // A read may issue only if its data will find a free slot (output or skid) when it returns.
  assign issue   = (state_q == DUMP) && (rd_cnt_q < len_q) && ((occ - {1'b0, pop}) <= 2'd1);

  always_comb begin
    o_v_d = dv_q;
    o_d_d = dd_q;
    s_v_d = sv_q;
    s_d_d = sd_q;
    if (pop) begin
      o_v_d = sv_q;
      o_d_d = sd_q;
      s_v_d = 1'b0;
    end
    if (pend_q) begin
      if (!o_v_d) begin
        o_v_d = 1'b1;
        o_d_d = ram_rdata;
      end else begin
        s_v_d = 1'b1;
        s_d_d = ram_rdata;
      end
    end
  end

  always_comb begin
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    ram_addr  = '0;
    ram_wdata = din;
    if (!rst) begin
      unique case (state_q)
        LOAD: begin
          ram_we    = ld_fire;
          ram_addr  = ld_cnt_q[ADDR_W-1:0];
          ram_wdata = strm.ld_data;
        end
        RUN: begin
          ram_we   = write;
          ram_re   = read;
          ram_addr = addr;
        end
        DUMP: begin
          ram_re   = issue;
          ram_addr = rd_cnt_q[ADDR_W-1:0];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      len_q        <= '0;
      ld_cnt_q     <= '0;
      rd_cnt_q     <= '0;
      out_cnt_q    <= '0;
      ld_ready_q   <= 1'b0;
      rd_done_q    <= 1'b0;
      wr_done_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      dout_hold_q  <= '0;
      pend_q       <= 1'b0;
      dv_q         <= 1'b0;
      dd_q         <= '0;
      sv_q         <= 1'b0;
      sd_q         <= '0;
    end else begin
      rd_done_q    <= 1'b0;
      wr_done_q    <= 1'b0;
      dout_valid_q <= 1'b0;
      if (dout_valid_q) dout_hold_q <= ram_rdata;
      unique case (state_q)
        IDLE: begin
          if (rd_en) begin
            len_q      <= len;
            ld_cnt_q   <= '0;
            ld_ready_q <= (len != '0);
            state_q    <= LOAD;
          end
        end
        LOAD: begin
          if (len_q == '0) begin
            rd_done_q <= 1'b1;
            state_q   <= RUN;
          end else if (ld_fire) begin
            ld_cnt_q <= ld_cnt_q + CNT_ONE;
            if (ld_cnt_q + CNT_ONE == len_q) begin
              ld_ready_q <= 1'b0;
              rd_done_q  <= 1'b1;
              state_q    <= RUN;
            end
          end
        end
        RUN: begin
          dout_valid_q <= read;
          if (wr_en) begin
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
            pend_q    <= 1'b0;
            dv_q      <= 1'b0;
            sv_q      <= 1'b0;
            state_q   <= DUMP;
          end
        end
        DUMP: begin
          pend_q <= issue;
          if (issue) rd_cnt_q <= rd_cnt_q + CNT_ONE;
          dv_q <= o_v_d;
          dd_q <= o_d_d;
          sv_q <= s_v_d;
          sd_q <= s_d_d;
          if (len_q == '0) begin
            wr_done_q <= 1'b1;
            state_q   <= IDLE;
          end else if (pop) begin
            out_cnt_q <= out_cnt_q + CNT_ONE;
            if (out_cnt_q + CNT_ONE == len_q) begin
              dv_q      <= 1'b0;
              wr_done_q <= 1'b1;
              state_q   <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // RAM output is shown only on the cycle after a RUN read; dump reads must not disturb dout.
  assign dout            = dout_valid_q ? ram_rdata : dout_hold_q;
  assign dout_valid      = dout_valid_q;
  assign rd_done         = rd_done_q;
  assign wr_done         = wr_done_q;
  assign state           = state_q;
  assign strm.ld_ready   = ld_ready_q;
  assign strm.dump_valid = dv_q;
  assign strm.dump_data  = dd_q;
endmodule

// File: tb/tb_dmem_stream.sv
// Scoreboard bench for dmem_stream: a 64K-word and a 16-word instance driven in lockstep.
module tb_dmem_stream;
  import dmem_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, rd_en, read, write, wr_en, ld_valid, dump_ready;
  logic [16:0] len;
  logic [15:0] addr;
  logic [7:0]  din, ld_data;

  logic       b_rd_done, b_dout_valid, b_wr_done, s_rd_done, s_dout_valid, s_wr_done;
  logic [7:0] b_dout, s_dout;
  logic [1:0] b_state, s_state;

  dmem_stream_if #(.DATA_W(8)) if_b ();
  dmem_stream_if #(.DATA_W(8)) if_s ();

  assign if_b.ld_valid   = ld_valid;
  assign if_b.ld_data    = ld_data;
  assign if_b.dump_ready = dump_ready;
  assign if_s.ld_valid   = ld_valid;
  assign if_s.ld_data    = ld_data;
  assign if_s.dump_ready = dump_ready;

  dmem_stream #(.DATA_W(8), .ADDR_W(16)) u_big (
    .clk(clk), .rst(rst), .rd_en(rd_en), .len(len), .rd_done(b_rd_done),
    .addr(addr), .read(read), .write(write), .din(din),
    .dout(b_dout), .dout_valid(b_dout_valid), .wr_en(wr_en), .wr_done(b_wr_done),
    .state(b_state), .strm(if_b)
  );

  dmem_stream #(.DATA_W(8), .ADDR_W(4)) u_small (
    .clk(clk), .rst(rst), .rd_en(rd_en), .len(len[4:0]), .rd_done(s_rd_done),
    .addr(addr[3:0]), .read(read), .write(write), .din(din),
    .dout(s_dout), .dout_valid(s_dout_valid), .wr_en(wr_en), .wr_done(s_wr_done),
    .state(s_state), .strm(if_s)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] ref_mem [16];
  logic [7:0] rd_q[$];
  logic [7:0] dp_b[$];
  logic [7:0] dp_s[$];
  int rdp_b, rdp_s, wdp_b, wdp_s, beats_b, beats_s;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // One clock: dump handshakes are judged just before the edge, registered outputs just after.
  task automatic tick();
    logic       exp_dv, hs_b, hs_s, st_b, st_s;
    logic [7:0] held_b, held_s, e;
    exp_dv = read && !rst;
    hs_b   = if_b.dump_valid && dump_ready && !rst;
    hs_s   = if_s.dump_valid && dump_ready && !rst;
    st_b   = if_b.dump_valid && !dump_ready && !rst;
    st_s   = if_s.dump_valid && !dump_ready && !rst;
    held_b = if_b.dump_data;
    held_s = if_s.dump_data;
    if (hs_b) begin
      beats_b++;
      if (dp_b.size() == 0) check("dump_extra_b", 32'(1), 32'(0));
      else begin e = dp_b.pop_front(); check("dump_data_b", 32'(held_b), 32'(e)); end
    end
    if (hs_s) begin
      beats_s++;
      if (dp_s.size() == 0) check("dump_extra_s", 32'(1), 32'(0));
      else begin e = dp_s.pop_front(); check("dump_data_s", 32'(held_s), 32'(e)); end
    end
    @(posedge clk);
    #1;
    if (st_b) check("stall_hold_b", 32'({if_b.dump_valid, if_b.dump_data}), 32'({1'b1, held_b}));
    if (st_s) check("stall_hold_s", 32'({if_s.dump_valid, if_s.dump_data}), 32'({1'b1, held_s}));
    check("dout_valid_b", 32'(b_dout_valid), 32'(exp_dv));
    check("dout_valid_s", 32'(s_dout_valid), 32'(exp_dv));
    if (exp_dv && rd_q.size() != 0) begin
      e = rd_q.pop_front();
      check("dout_b", 32'(b_dout), 32'(e));
      check("dout_s", 32'(s_dout), 32'(e));
    end
    if (b_rd_done) rdp_b++;
    if (s_rd_done) rdp_s++;
    if (b_wr_done) begin wdp_b++; check("wr_done_idle_b", 32'(b_state), 32'(IDLE)); end
    if (s_wr_done) begin wdp_s++; check("wr_done_idle_s", 32'(s_state), 32'(IDLE)); end
  endtask

  task automatic do_load(input int n, input bit gaps, input int base);
    int idx, c;
    rd_en = 1'b1;
    len   = 17'(n);
    tick();
    rd_en = 1'b0;
    check("load_state_b", 32'(b_state), 32'(LOAD));
    check("load_state_s", 32'(s_state), 32'(LOAD));
    check("ld_ready_rise_b", 32'(if_b.ld_ready), 32'(n != 0));
    check("ld_ready_rise_s", 32'(if_s.ld_ready), 32'(n != 0));
    rdp_b = 0; rdp_s = 0; idx = 0; c = 0;
    while (!(b_state == RUN && s_state == RUN) && c < 200) begin
      ld_valid = (idx < n) && (!gaps || (c % 3) != 2);
      ld_data  = 8'(base + idx * 17);
      if (ld_valid && if_b.ld_ready) begin
        ref_mem[idx % 16] = ld_data;
        idx++;
      end
      tick();
      c++;
    end
    ld_valid = 1'b0;
    check("load_beats", 32'(idx), 32'(n));
    check("rd_done_cnt_b", 32'(rdp_b), 32'(1));
    check("rd_done_cnt_s", 32'(rdp_s), 32'(1));
    check("run_state_b", 32'(b_state), 32'(RUN));
    check("run_state_s", 32'(s_state), 32'(RUN));
    if (!gaps) check("load_cycles", 32'(c), 32'((n == 0) ? 1 : n));
  endtask

  task automatic run_op(input bit rd, input bit wr, input int a, input logic [7:0] d);
    read  = rd;
    write = wr;
    addr  = 16'(a);
    din   = d;
    if (rd) rd_q.push_back(ref_mem[a]);
    if (wr) ref_mem[a] = d;
    tick();
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic do_dump(input int n, input bit toggle, input bit acc);
    logic [6:0] pat = 7'b1011001;
    int c, pi, first, done_at;
    if (acc) begin
      write = 1'b1; addr = 16'd3; din = 8'h77;
      ref_mem[3] = 8'h77;
    end
    for (int i = 0; i < n; i++) begin
      dp_b.push_back(ref_mem[i]);
      dp_s.push_back(ref_mem[i]);
    end
    wr_en = 1'b1;
    tick();
    wr_en = 1'b0; write = 1'b0;
    beats_b = 0; beats_s = 0; wdp_b = 0; wdp_s = 0;
    c = 0; pi = 0; first = -1; done_at = -1;
    while (!(b_state == IDLE && s_state == IDLE) && c < 200) begin
      dump_ready = toggle ? pat[pi % 7] : 1'b1;
      if (if_b.dump_valid) pi++;
      tick();
      c++;
      if (first < 0 && if_b.dump_valid) first = c;
      if (b_wr_done) done_at = c;
    end
    dump_ready = 1'b0;
    check("dump_beats_b", 32'(beats_b), 32'(n));
    check("dump_beats_s", 32'(beats_s), 32'(n));
    check("wr_done_cnt_b", 32'(wdp_b), 32'(1));
    check("wr_done_cnt_s", 32'(wdp_s), 32'(1));
    check("dump_left_b", 32'(dp_b.size()), 32'(0));
    check("dump_left_s", 32'(dp_s.size()), 32'(0));
    check("idle_state_b", 32'(b_state), 32'(IDLE));
    check("idle_state_s", 32'(s_state), 32'(IDLE));
    if (n > 0) check("first_valid_lat", 32'(first), 32'(2));
    if (n > 0 && !toggle) check("no_bubbles", 32'(done_at - first), 32'(n));
    dp_b.delete();
    dp_s.delete();
  endtask

  initial begin
    rst = 1'b1; rd_en = 1'b0; read = 1'b0; write = 1'b0; wr_en = 1'b0;
    ld_valid = 1'b0; dump_ready = 1'b0; len = '0; addr = '0; din = '0; ld_data = '0;
    rdp_b = 0; rdp_s = 0; wdp_b = 0; wdp_s = 0; beats_b = 0; beats_s = 0;
    tick(); tick();
    check("reset_outs_b", 32'({b_state, if_b.ld_ready, b_rd_done, b_wr_done, b_dout, b_dout_valid,
                               if_b.dump_valid, if_b.dump_data}), 32'(0));
    check("reset_outs_s", 32'({s_state, if_s.ld_ready, s_rd_done, s_wr_done, s_dout, s_dout_valid,
                               if_s.dump_valid, if_s.dump_data}), 32'(0));
    rst = 1'b0;
    tick();

    // Load four words with valid gaps, then read them back.
    do_load(4, 1'b1, 8'h11);
    for (int a = 0; a < 4; a++) run_op(1'b1, 1'b0, a, 8'h00);

    // Same-cycle read and write is read-first; dout holds between reads.
    run_op(1'b0, 1'b1, 5, 8'h5A);
    run_op(1'b1, 1'b1, 5, 8'hAB);
    run_op(1'b1, 1'b0, 5, 8'h00);
    tick();
    check("dout_hold_b", 32'(b_dout), 32'(8'hAB));
    check("dout_hold_s", 32'(s_dout), 32'(8'hAB));
    run_op(1'b0, 1'b1, 2, 8'h5C);

    // Dump with stalls; the wr_en cycle also carries a write that must land.
    do_dump(4, 1'b1, 1'b1);

    // Zero-length image.
    do_load(0, 1'b0, 0);
    do_dump(0, 1'b0, 1'b0);

    // Reset in the middle of a load aborts silently; a reload then works.
    rd_en = 1'b1; len = 17'd4;
    tick();
    rd_en = 1'b0; rdp_b = 0; rdp_s = 0;
    ld_valid = 1'b1; ld_data = 8'hE1; ref_mem[0] = 8'hE1;
    tick();
    ld_data = 8'hE2; ref_mem[1] = 8'hE2;
    tick();
    ld_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_state_b", 32'({b_state, if_b.ld_ready}), 32'({IDLE, 1'b0}));
    check("abort_state_s", 32'({s_state, if_s.ld_ready}), 32'({IDLE, 1'b0}));
    tick();
    check("abort_no_done", 32'(rdp_b + rdp_s), 32'(0));
    do_load(4, 1'b0, 8'hA1);
    for (int a = 0; a < 4; a++) run_op(1'b1, 1'b0, a, 8'h00);
    do_dump(4, 1'b0, 1'b0);

    // Full memory of the small instance at full throughput.
    do_load(16, 1'b0, 8'h05);
    run_op(1'b1, 1'b0, 15, 8'h00);
    run_op(1'b1, 1'b0, 0, 8'h00);
    do_dump(16, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
